// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and ASCII digit helpers for decimal-entry converters
package bcd_pkg;

    localparam int DIGITS = 6;
    localparam int DATA_W = 20;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic {
        IDLE,
        CONV
    } state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

    // Non-digits yield a garbage nibble; callers mask the result via the error flag.
    function automatic logic [3:0] digit_val(input logic [7:0] c);
        logic [7:0] v;
        v = c - ASCII_ZERO;
        return v[3:0];
    endfunction

endpackage

// File: rtl/mul10_add.sv
// mul10_add: combinational Horner step, sum = acc*10 + digit, built from shifts and adds
module mul10_add #(
    parameter int DATA_W = 20
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] sum
);

    assign sum = (acc << 3) + (acc << 1) + DATA_W'(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: converts six captured ASCII decimal digits to binary, one digit per cycle
module bcd_to_bin #(
    parameter int DIGITS = 6,
    parameter int DATA_W = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [7:0]        h_hun,
    input  logic [7:0]        t_tho,
    input  logic [7:0]        tho,
    input  logic [7:0]        hun,
    input  logic [7:0]        ten,
    input  logic [7:0]        unit,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import bcd_pkg::*;

    localparam logic [2:0] LAST = 3'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d;
    logic                  bad_q, bad_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     step;

    // Captured digits shift left each step so the current MSD is always the top nibble.
    mul10_add #(.DATA_W(DATA_W)) u_mul10_add (
        .acc   (acc_q),
        .digit (dig_q[4*DIGITS-1 -: 4]),
        .sum   (step)
    );

    // Next-state: capture on start in IDLE, one Horner step per cycle in CONV
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dig_d   = dig_q;
        bad_d   = bad_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = CONV;
                cnt_d   = '0;
                acc_d   = '0;
                dig_d   = {digit_val(h_hun), digit_val(t_tho), digit_val(tho),
                           digit_val(hun), digit_val(ten), digit_val(unit)};
                bad_d   = !(is_digit(h_hun) && is_digit(t_tho) && is_digit(tho) &&
                            is_digit(hun) && is_digit(ten) && is_digit(unit));
                busy_d  = 1'b1;
            end
        end else begin
            acc_d = step;
            dig_d = dig_q << 4;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                data_d  = bad_q ? '0 : step;
                err_d   = bad_q;
            end
        end
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dig_q   <= '0;
            bad_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dig_q   <= dig_d;
            bad_q   <= bad_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed scoreboard bench for the ASCII-to-binary converter
module tb_bcd_to_bin;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  h_hun = 8'h30, t_tho = 8'h30, tho = 8'h30;
    logic [7:0]  hun = 8'h30, ten = 8'h30, unit = 8'h30;
    logic [19:0] data;
    logic        busy, done, err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [20:0] sb[$];
    int          mcnt = 0;
    logic        exp_done = 1'b0;
    logic [19:0] hold_data = '0;
    logic        hold_err = 1'b0;
    logic        mon_en = 1'b0;

    bcd_to_bin dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .h_hun     (h_hun),
        .t_tho     (t_tho),
        .tho       (tho),
        .hun       (hun),
        .ten       (ten),
        .unit      (unit),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference conversion: {err, data} from six ASCII bytes, MSD in the top byte
    function automatic logic [20:0] ref_conv(input logic [47:0] s);
        int   v;
        logic bad;
        logic [7:0] b;
        v = 0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b = s[47 - 8*i -: 8];
            if (b < 8'h30 || b > 8'h39) bad = 1'b1;
            else v = v * 10 + int'(b - 8'h30);
        end
        return bad ? {1'b1, 20'd0} : {1'b0, 20'(v)};
    endfunction

    task automatic set_digits(input string s);
        h_hun = s[0]; t_tho = s[1]; tho = s[2]; hun = s[3]; ten = s[4]; unit = s[5];
    endtask

    // Cycle model: capture when idle and start sampled, six steps later done
    initial forever begin
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            mcnt = 0;
            exp_done = 1'b0;
            sb.delete();
            hold_data = '0;
            hold_err = 1'b0;
        end else if (mcnt == 0 && start) begin
            sb.push_back(ref_conv({h_hun, t_tho, tho, hun, ten, unit}));
            mcnt = 6;
            exp_done = 1'b0;
        end else if (mcnt > 0) begin
            mcnt--;
            exp_done = (mcnt == 0);
        end else begin
            exp_done = 1'b0;
        end
    end

    // Monitor: done/busy timing every cycle, results popped from the scoreboard on done
    initial forever begin
        logic [20:0] e;
        @(negedge sys_clk);
        if (mon_en) begin
            check("done_timing", 32'(done), 32'(exp_done));
            check("busy", 32'(busy), 32'(mcnt != 0));
            if (done) begin
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    hold_data = e[19:0];
                    hold_err = e[20];
                end
            end
            check("data_hold", 32'(data), 32'(hold_data));
            check("err_hold", 32'(err), 32'(hold_err));
        end
    end

    task automatic go(input string s, output int lat);
        @(negedge sys_clk);
        set_digits(s);
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge sys_clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 20);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((sb.size() != 0 || mcnt != 0) && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("settle_timeout", 32'(n < 20), 32'd1);
    endtask

    initial begin
        int lat;
        int dones;
        repeat (3) @(negedge sys_clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        sys_rst_n = 1'b1;
        mon_en = 1'b1;

        go("123456", lat);
        check("lat_123456", 32'(lat), 32'd7);
        check("data_123456", 32'(data), 32'h1E240);
        check("err_123456", 32'(err), 32'd0);
        settle();

        go("999999", lat);
        check("data_999999", 32'(data), 32'hF423F);
        check("err_999999", 32'(err), 32'd0);
        go("000000", lat);
        check("data_000000", 32'(data), 32'd0);
        check("err_000000", 32'(err), 32'd0);

        go("12A456", lat);
        check("lat_12A456", 32'(lat), 32'd7);
        check("data_12A456", 32'(data), 32'd0);
        check("err_12A456", 32'(err), 32'd1);
        go("000042", lat);
        check("data_000042", 32'(data), 32'd42);
        check("err_000042", 32'(err), 32'd0);
        settle();

        @(negedge sys_clk);
        set_digits("000007");
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (done) dones++;
        end
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge sys_clk);
            if (done) dones++;
        end
        check("held_start_dones", 32'(dones), 32'd2);
        check("data_000007", 32'(data), 32'd7);
        settle();

        @(negedge sys_clk);
        set_digits("111111");
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        set_digits("98765X");
        settle();
        check("data_captured", 32'(data), 32'd111111);
        check("err_captured", 32'(err), 32'd0);

        @(negedge sys_clk);
        set_digits("654321");
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        go("654321", lat);
        check("lat_654321", 32'(lat), 32'd7);
        check("data_654321", 32'(data), 32'd654321);
        check("err_654321", 32'(err), 32'd0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
